// File: rtl/regfile_pkg.sv
// Shared register encodings and defaults for the register file.
// Imported by the scoreboarded register file and its entries.
package regfile_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 4;
  localparam int NREG_DEF   = 15;
  localparam int CNT_W_DEF  = 2;

  typedef enum logic [ADDR_W_DEF-1:0] {
    RAX   = 4'd0,
    RCX   = 4'd1,
    RDX   = 4'd2,
    RBX   = 4'd3,
    RSP   = 4'd4,
    RBP   = 4'd5,
    RSI   = 4'd6,
    RDI   = 4'd7,
    R8    = 4'd8,
    R9    = 4'd9,
    R10   = 4'd10,
    R11   = 4'd11,
    R12   = 4'd12,
    R13   = 4'd13,
    R14   = 4'd14,
    RNONE = 4'd15
  } reg_e;

  function automatic logic is_valid_reg(input int idx, input int nreg);
    return idx < nreg;
  endfunction

endpackage

// File: rtl/pipe_regfile_sb_entry.sv
// One architectural register: data flop plus pending-write counter.
// Counter nets claims against write-backs and saturates at zero.
module rf_entry
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              fire,
  input  logic [1:0]        inc,
  input  logic [1:0]        dec,
  output logic [DATA_W-1:0] value,
  output logic              busy,
  output logic              ovf_would,
  output logic              udf
);

  localparam int SW = CNT_W + 2;
  localparam logic [SW-1:0] MAXC = SW'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] cnt;
  logic [SW-1:0]    cnt_x;
  logic [SW-1:0]    claim;
  logic [SW-1:0]    up;

  always_comb begin
    cnt_x     = SW'(cnt);
    claim     = cnt_x + SW'(inc);
    // ovf is judged on the claim alone so ready never depends on fire
    ovf_would = claim > (MAXC + SW'(dec));
    up        = fire ? claim : cnt_x;
    udf       = SW'(dec) > up;
    busy      = |cnt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      value <= '0;
      cnt   <= '0;
    end else begin
      if (wr_en) value <= wr_data;
      cnt <= udf ? '0 : CNT_W'(up - SW'(dec));
    end
  end

endmodule

// File: rtl/pipe_regfile_sb.sv
// Register file with two read ports, two write-back ports and
// a per-register pending-write scoreboard with optional bypass.
module pipe_regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int BYPASS = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] srcA,
  output logic [DATA_W-1:0] valA,
  output logic              busyA,
  input  logic [ADDR_W-1:0] srcB,
  output logic [DATA_W-1:0] valB,
  output logic              busyB,
  input  logic [ADDR_W-1:0] dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [ADDR_W-1:0] dstM,
  input  logic [DATA_W-1:0] valM,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dstE,
  input  logic [ADDR_W-1:0] issue_dstM,
  output logic              issue_ready,
  output logic              err
);

  logic [DATA_W-1:0] rf_q [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   ovf;
  logic [NREG-1:0]   udf;
  logic              fire;

  assign issue_ready = ~|ovf;
  assign fire        = issue_valid & issue_ready;

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);
    logic       hit_e;
    logic       hit_m;
    logic [1:0] inc;
    logic [1:0] dec;

    assign hit_e = dstE == IDX;
    assign hit_m = dstM == IDX;
    assign inc   = 2'(issue_valid && issue_dstE == IDX)
                 + 2'(issue_valid && issue_dstM == IDX);
    assign dec   = 2'(hit_e) + 2'(hit_m);

    rf_entry #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_entry (
      .clock     (clock),
      .reset     (reset),
      .wr_en     (hit_e | hit_m),
      .wr_data   (hit_m ? valM : valE),
      .fire      (fire),
      .inc       (inc),
      .dec       (dec),
      .value     (rf_q[i]),
      .busy      (busy_q[i]),
      .ovf_would (ovf[i]),
      .udf       (udf[i])
    );
  end

  function automatic logic [DATA_W-1:0] rd_val(
    input logic [ADDR_W-1:0] s
  );
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++)
      if (s == ADDR_W'(i)) v = rf_q[i];
    if (BYPASS != 0 && is_valid_reg(int'(s), NREG)) begin
      if (s == dstM)      v = valM;
      else if (s == dstE) v = valE;
    end
    return v;
  endfunction

  function automatic logic rd_busy(input logic [ADDR_W-1:0] s);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NREG; i++)
      if (s == ADDR_W'(i)) b = busy_q[i];
    return b;
  endfunction

  always_comb begin
    valA  = rd_val(srcA);
    valB  = rd_val(srcB);
    busyA = rd_busy(srcA);
    busyB = rd_busy(srcB);
  end

  always_ff @(posedge clock) begin
    if (reset)     err <= 1'b0;
    else if (|udf) err <= 1'b1;
  end

endmodule

// File: tb/tb_pipe_regfile_sb.sv
// Self-checking bench: directed scenarios plus random traffic
// against an array-based model, on bypass and non-bypass copies.
module tb_pipe_regfile_sb;

  logic        clock = 0;
  logic        reset;
  logic [3:0]  srcA, srcB, dstE, dstM, issue_dstE, issue_dstM;
  logic [63:0] valE, valM;
  logic        issue_valid;

  logic [63:0] a_valA, a_valB, b_valA, b_valB;
  logic        a_busyA, a_busyB, b_busyA, b_busyB;
  logic        a_rdy, b_rdy, a_err, b_err;

  int nchk = 0;
  int npass = 0;

  always #5 clock = ~clock;

  pipe_regfile_sb u_dut (
    .clock(clock), .reset(reset),
    .srcA(srcA), .valA(a_valA), .busyA(a_busyA),
    .srcB(srcB), .valB(a_valB), .busyB(a_busyB),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .issue_valid(issue_valid), .issue_dstE(issue_dstE),
    .issue_dstM(issue_dstM), .issue_ready(a_rdy), .err(a_err)
  );

  pipe_regfile_sb #(.NREG(8), .BYPASS(0)) u_nb (
    .clock(clock), .reset(reset),
    .srcA(srcA), .valA(b_valA), .busyA(b_busyA),
    .srcB(srcB), .valB(b_valB), .busyB(b_busyB),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .issue_valid(issue_valid), .issue_dstE(issue_dstE),
    .issue_dstM(issue_dstM), .issue_ready(b_rdy), .err(b_err)
  );

  // model: k=0 is u_dut (NREG 15, bypass), k=1 is u_nb (NREG 8)
  int          nr [2] = '{15, 8};
  bit          byp [2] = '{1'b1, 1'b0};
  logic [63:0] m_reg [2][16];
  int          m_cnt [2][16];
  bit          m_err [2];

  function automatic int nclaim(int k, int r);
    if (!issue_valid || r >= nr[k]) return 0;
    return int'(issue_dstE == 4'(r)) + int'(issue_dstM == 4'(r));
  endfunction

  function automatic int ndec(int k, int r);
    if (r >= nr[k]) return 0;
    return int'(dstE == 4'(r)) + int'(dstM == 4'(r));
  endfunction

  function automatic bit m_ready(int k);
    for (int r = 0; r < nr[k]; r++)
      if (m_cnt[k][r] + nclaim(k, r) - ndec(k, r) > 3) return 0;
    return 1;
  endfunction

  function automatic logic [63:0] m_val(int k, int s);
    if (s >= nr[k]) return 64'd0;
    if (byp[k] && int'(dstM) == s) return valM;
    if (byp[k] && int'(dstE) == s) return valE;
    return m_reg[k][s];
  endfunction

  function automatic bit m_busy(int k, int s);
    return s < nr[k] && m_cnt[k][s] != 0;
  endfunction

  function automatic void model_edge(int k);
    bit f;
    int up;
    if (reset) begin
      for (int r = 0; r < 16; r++) begin
        m_reg[k][r] = 0;
        m_cnt[k][r] = 0;
      end
      m_err[k] = 0;
      return;
    end
    f = issue_valid && m_ready(k);
    for (int r = 0; r < nr[k]; r++) begin
      up = m_cnt[k][r] + (f ? nclaim(k, r) : 0);
      if (ndec(k, r) > up) begin
        m_cnt[k][r] = 0;
        m_err[k] = 1;
      end else begin
        m_cnt[k][r] = up - ndec(k, r);
      end
    end
    if (int'(dstE) < nr[k]) m_reg[k][dstE] = valE;
    if (int'(dstM) < nr[k]) m_reg[k][dstM] = valM;
  endfunction

  task automatic tick();
    @(posedge clock);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic idle();
    reset = 0;
    dstE = 4'd15; dstM = 4'd15;
    valE = 0; valM = 0;
    issue_valid = 0; issue_dstE = 4'd15; issue_dstM = 4'd15;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    srcA = 0; srcB = 4'd3;
    @(negedge clock);
    nchk++;
    if (a_valA !== 0 || a_busyA !== 0 || a_err !== 0 || a_rdy !== 1)
      $display("FAIL reset_dut: val=%h busy=%b err=%b rdy=%b want 0/0/0/1",
               a_valA, a_busyA, a_err, a_rdy);
    else npass++;
    nchk++;
    if (b_valB !== 0 || b_busyB !== 0 || b_err !== 0 || b_rdy !== 1)
      $display("FAIL reset_nb: val=%h busy=%b err=%b rdy=%b want 0/0/0/1",
               b_valB, b_busyB, b_err, b_rdy);
    else npass++;
  endtask

  task automatic test_same_dst();
    idle();
    dstE = 0; valE = 64'h1111;
    dstM = 0; valM = 64'h2222;
    tick();
    idle();
    srcA = 0;
    @(negedge clock);
    nchk++;
    if (a_valA !== 64'h2222 || b_valA !== 64'h2222)
      $display("FAIL same_dst: got %h/%h want 2222", a_valA, b_valA);
    else npass++;
  endtask

  task automatic test_bypass();
    idle();
    dstE = 3; valE = 64'h5;
    tick();
    idle();
    dstE = 3; valE = 64'hAB; srcB = 3;
    @(negedge clock);
    nchk++;
    if (a_valB !== 64'hAB)
      $display("FAIL bypass_on: got %h want ab", a_valB);
    else npass++;
    nchk++;
    if (b_valB !== 64'h5)
      $display("FAIL bypass_off_same: got %h want 5", b_valB);
    else npass++;
    tick();
    idle();
    @(negedge clock);
    nchk++;
    if (b_valB !== 64'hAB || a_valB !== 64'hAB)
      $display("FAIL bypass_off_next: got %h/%h want ab", a_valB, b_valB);
    else npass++;
  endtask

  task automatic test_issue_ovf();
    do_reset();
    srcA = 2;
    issue_valid = 1; issue_dstE = 2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      nchk++;
      if (a_rdy !== 1 || b_rdy !== 1)
        $display("FAIL issue_%0d_ready: got %b/%b want 1", k, a_rdy, b_rdy);
      else npass++;
      tick();
    end
    @(negedge clock);
    nchk++;
    if (a_busyA !== 1 || b_busyA !== 1 || a_rdy !== 0 || b_rdy !== 0)
      $display("FAIL issue_full: busy=%b/%b rdy=%b/%b want 1/1 0/0",
               a_busyA, b_busyA, a_rdy, b_rdy);
    else npass++;
    tick();
    issue_valid = 0; dstE = 2; valE = 64'h77;
    @(negedge clock);
    nchk++;
    if (a_rdy !== 1 || b_rdy !== 1)
      $display("FAIL issue_idle_ready: got %b/%b want 1", a_rdy, b_rdy);
    else npass++;
    tick();
    dstE = 4'd15; issue_valid = 1;
    @(negedge clock);
    nchk++;
    if (a_rdy !== 1 || b_rdy !== 1 || a_busyA !== 1)
      $display("FAIL issue_after_wb: rdy=%b/%b busy=%b want 1/1 1",
               a_rdy, b_rdy, a_busyA);
    else npass++;
    tick();
    @(negedge clock);
    nchk++;
    if (a_rdy !== 0 || b_rdy !== 0)
      $display("FAIL issue_refull: got %b/%b want 0", a_rdy, b_rdy);
    else npass++;
    dstE = 2; valE = 64'h99;
    @(negedge clock);
    nchk++;
    if (a_rdy !== 1 || b_rdy !== 1)
      $display("FAIL issue_net_ready: got %b/%b want 1", a_rdy, b_rdy);
    else npass++;
    idle();
  endtask

  task automatic test_net();
    do_reset();
    srcA = 5;
    issue_valid = 1; issue_dstE = 5;
    tick();
    dstM = 5; valM = 64'hC0DE;
    tick();
    idle();
    @(negedge clock);
    nchk++;
    if (a_busyA !== 1 || b_busyA !== 1 || a_err !== 0 || b_err !== 0)
      $display("FAIL net_hold: busy=%b/%b err=%b/%b want 1/1 0/0",
               a_busyA, b_busyA, a_err, b_err);
    else npass++;
    dstE = 5; valE = 64'hBEEF;
    tick();
    idle();
    @(negedge clock);
    nchk++;
    if (a_busyA !== 0 || b_busyA !== 0 || a_err !== 0 ||
        b_valA !== 64'hBEEF)
      $display("FAIL net_drain: busy=%b/%b err=%b val=%h want 0/0 0 beef",
               a_busyA, b_busyA, a_err, b_valA);
    else npass++;
  endtask

  task automatic test_err();
    do_reset();
    srcA = 7;
    dstE = 7; valE = 64'h42;
    @(negedge clock);
    nchk++;
    if (a_err !== 0)
      $display("FAIL err_pre: got %b want 0", a_err);
    else npass++;
    tick();
    idle();
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      nchk++;
      if (a_err !== 1 || b_err !== 1 || a_busyA !== 0 || b_busyA !== 0)
        $display("FAIL err_sticky_%0d: err=%b/%b busy=%b/%b want 1/1 0/0",
                 k, a_err, b_err, a_busyA, b_busyA);
      else npass++;
      tick();
    end
    do_reset();
    @(negedge clock);
    nchk++;
    if (a_err !== 0 || b_err !== 0)
      $display("FAIL err_clear: got %b/%b want 0", a_err, b_err);
    else npass++;
  endtask

  task automatic test_none();
    idle();
    issue_valid = 1; issue_dstE = 10; issue_dstM = 10;
    tick();
    dstE = 10; valE = 64'hDEAD;
    issue_valid = 0;
    tick();
    idle();
    @(negedge clock);
    srcA = 4'd15; srcB = 4'd10;
    #1;
    nchk++;
    if (a_valA !== 0 || a_busyA !== 0 || b_valB !== 0 || b_busyB !== 0)
      $display("FAIL none_read: %h/%b %h/%b want 0/0 0/0",
               a_valA, a_busyA, b_valB, b_busyB);
    else npass++;
    nchk++;
    if (a_valB !== 64'hDEAD || a_busyB !== 1)
      $display("FAIL reg10_read: %h/%b want dead/1", a_valB, a_busyB);
    else npass++;
    dstE = 4'd15; valE = {$urandom, $urandom};
    dstM = 4'd15; valM = {$urandom, $urandom};
    tick();
    idle();
    for (int r = 0; r < 15; r++) begin
      srcA = 4'(r);
      #1;
      nchk++;
      if (a_valA !== m_val(0, r) || b_valA !== m_val(1, r))
        $display("FAIL none_write_r%0d: %h/%h want %h/%h",
                 r, a_valA, b_valA, m_val(0, r), m_val(1, r));
      else npass++;
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      idle();
      srcA = 4'($urandom_range(0, 15));
      srcB = 4'($urandom_range(0, 15));
      valE = {$urandom, $urandom};
      valM = {$urandom, $urandom};
      r = $urandom_range(0, 15);
      if (r < 15 && m_cnt[0][r] > 0 && (r >= 8 || m_cnt[1][r] > 0))
        dstE = 4'(r);
      r = $urandom_range(0, 15);
      if (r < 15 && m_cnt[0][r] - int'(dstE == 4'(r)) > 0 &&
          (r >= 8 || m_cnt[1][r] - int'(dstE == 4'(r)) > 0))
        dstM = 4'(r);
      issue_valid = 1'($urandom_range(0, 1));
      issue_dstE = 4'($urandom_range(0, 15));
      issue_dstM = 4'($urandom_range(0, 15));
      @(negedge clock);
      nchk++;
      if (a_valA !== m_val(0, int'(srcA)) ||
          a_valB !== m_val(0, int'(srcB)) ||
          a_busyA !== m_busy(0, int'(srcA)) ||
          a_busyB !== m_busy(0, int'(srcB)) ||
          a_rdy !== m_ready(0) || a_err !== m_err[0])
        $display("FAIL rand_dut_%0d: A=%h/%b B=%h/%b rdy=%b err=%b want %h/%b %h/%b %b %b",
                 n, a_valA, a_busyA, a_valB, a_busyB, a_rdy, a_err,
                 m_val(0, int'(srcA)), m_busy(0, int'(srcA)),
                 m_val(0, int'(srcB)), m_busy(0, int'(srcB)),
                 m_ready(0), m_err[0]);
      else npass++;
      nchk++;
      if (b_valA !== m_val(1, int'(srcA)) ||
          b_valB !== m_val(1, int'(srcB)) ||
          b_busyA !== m_busy(1, int'(srcA)) ||
          b_busyB !== m_busy(1, int'(srcB)) ||
          b_rdy !== m_ready(1) || b_err !== m_err[1])
        $display("FAIL rand_nb_%0d: A=%h/%b B=%h/%b rdy=%b err=%b want %h/%b %h/%b %b %b",
                 n, b_valA, b_busyA, b_valB, b_busyB, b_rdy, b_err,
                 m_val(1, int'(srcA)), m_busy(1, int'(srcA)),
                 m_val(1, int'(srcB)), m_busy(1, int'(srcB)),
                 m_ready(1), m_err[1]);
      else npass++;
      tick();
    end
  endtask

  initial begin
    srcA = 0; srcB = 0;
    idle();
    test_reset();
    test_same_dst();
    test_bypass();
    test_issue_ovf();
    test_net();
    test_err();
    test_none();
    test_random();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
